ps2_ascii_fifo: RTL and testbench

PS2_ASCII_FIFO -- requirements
Module: ps2_ascii_fifo

---
 rtl/ps2_ascii_fifo.sv | 164 ++++++++++++++++
 tb/tb_ps2_ascii_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_ascii_fifo.sv
// PS/2 keyboard receiver: synchronises the raw lines, frames and checks bytes, decodes make/break
// sequences into lowercase ASCII and buffers the characters in a small FIFO for the consumer.
module ps2_ascii_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] ascii,
  output logic       valid,
  input  logic       ready,
  output logic       overflow,
  output logic       frame_err,
  output logic [7:0] key_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_prev;
  logic          fall, dat_s;
  logic [3:0]    bit_cnt;
  logic [9:0]    shift;
  logic [TW-1:0] tmo_cnt;
  logic          last_bit, frame_ok, frame_bad, timeout;
  logic [7:0]    rx_byte;

  state_t        state, state_nxt;
  logic          push;
  logic [7:0]    push_chr;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, wr_en;

  function automatic logic [7:0] xlate(input logic [7:0] code);
    case (code)
      8'h1C: xlate = "a";  8'h32: xlate = "b";  8'h21: xlate = "c";  8'h23: xlate = "d";
      8'h24: xlate = "e";  8'h2B: xlate = "f";  8'h34: xlate = "g";  8'h33: xlate = "h";
      8'h43: xlate = "i";  8'h3B: xlate = "j";  8'h42: xlate = "k";  8'h4B: xlate = "l";
      8'h3A: xlate = "m";  8'h31: xlate = "n";  8'h44: xlate = "o";  8'h4D: xlate = "p";
      8'h15: xlate = "q";  8'h2D: xlate = "r";  8'h1B: xlate = "s";  8'h2C: xlate = "t";
      8'h3C: xlate = "u";  8'h2A: xlate = "v";  8'h1D: xlate = "w";  8'h22: xlate = "x";
      8'h35: xlate = "y";  8'h1A: xlate = "z";
      8'h45: xlate = "0";  8'h16: xlate = "1";  8'h1E: xlate = "2";  8'h26: xlate = "3";
      8'h25: xlate = "4";  8'h2E: xlate = "5";  8'h36: xlate = "6";  8'h3D: xlate = "7";
      8'h3E: xlate = "8";  8'h46: xlate = "9";
      8'h29: xlate = 8'h20;
      default: xlate = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall  = clk_prev & ~clk_sync[1];
  assign dat_s = dat_sync[1];

  // The stop bit is judged live on its own edge so a good byte lands in the FIFO on that same cycle.
  assign last_bit  = fall && (bit_cnt == 4'd10);
  assign frame_ok  = last_bit && !shift[0] && dat_s && (^shift[9:1]);
  assign frame_bad = last_bit && !frame_ok;
  assign timeout   = (bit_cnt != 4'd0) && !fall && (tmo_cnt == TMO_LAST);
  assign rx_byte   = shift[8:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= 4'd0;
      shift     <= 10'd0;
      tmo_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_bad | timeout;
      if (fall) begin
        tmo_cnt <= '0;
        shift   <= {dat_s, shift[9:1]};
        bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
      end else if (timeout) begin
        tmo_cnt <= '0;
        bit_cnt <= 4'd0;
      end else if (bit_cnt != 4'd0) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (frame_ok) begin
      case (state)
        IDLE: begin
          if (rx_byte == 8'hF0)      state_nxt = BREAK;
          else if (rx_byte == 8'hE0) state_nxt = EXT;
        end
        EXT:       state_nxt = (rx_byte == 8'hF0) ? EXT_BREAK : IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    push_chr = xlate(rx_byte);
    push     = frame_ok && (state == IDLE) && (rx_byte != 8'hF0) &&
               (rx_byte != 8'hE0) && (push_chr != 8'h00);
  end

  assign valid = (count != '0);
  assign ascii = valid ? mem[rd_ptr] : 8'h00;
  assign full  = (count == DEPTH_C);
  assign pop   = valid && ready;
  // A full FIFO still accepts a character when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_ptr] <= push_chr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      key_count <= 8'd0;
    end else begin
      if (wr_en) begin
        wr_ptr    <= wr_ptr + AW'(1);
        key_count <= key_count + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && !wr_en) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_ascii_fifo.sv
// Directed PS/2 frames drive the receiver; a negedge monitor pops expected characters from a scoreboard.
module tb_ps2_ascii_fifo;
  localparam int DEPTH = 8;
  localparam int TMO   = 200;
  localparam int H     = 6;

  logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_dat = 1'b1, ready = 1'b0;
  logic [7:0] ascii, key_count;
  logic       valid, overflow, frame_err;

  int n_cmp = 0, n_fail = 0, fe_cnt = 0, pop_cnt = 0, last_lat = 99;
  int fe0, p0;
  logic [7:0] exp_q[$];

  ps2_ascii_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .ascii(ascii), .valid(valid), .ready(ready), .overflow(overflow),
    .frame_err(frame_err), .key_count(key_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (!rst && valid && ready) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL pop_unexpected: got %0h expected no character", ascii);
      end else begin
        check("pop_ascii", int'(ascii), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      tick(H);
      ps2_clk = 1'b0;
      if (i == 10) begin
        last_lat = 99;
        for (int k = 1; k <= 4; k++) begin
          tick(1);
          if (valid && last_lat == 99) last_lat = k;
        end
        tick(H - 4);
      end else begin
        tick(H);
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    tick(2 * H);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_q.delete();
    tick(1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    ready = 1'b1;
    while (valid && k < 60) begin
      tick(1);
      k++;
    end
    ready = 1'b0;
    tick(1);
    check("drain_valid", int'(valid), 0);
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    check("rst_ascii", int'(ascii), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_key_count", int'(key_count), 0);

    // single make code, consumer stalled
    exp_q.push_back(8'h61);
    send(8'h1C);
    check("t1_latency_ok", int'(last_lat <= 4), 1);
    check("t1_valid", int'(valid), 1);
    check("t1_ascii", int'(ascii), 'h61);
    check("t1_key_count", int'(key_count), 1);
    drain();

    // make, break: one character, then decoder idle again
    exp_q.push_back(8'h61);
    send(8'h1C); send(8'hF0); send(8'h1C);
    check("t2_key_count", int'(key_count), 2);
    check("t2_ascii", int'(ascii), 'h61);
    exp_q.push_back(8'h61);
    send(8'h1C);
    check("t2_idle_key_count", int'(key_count), 3);
    drain();

    // bad parity
    fe0 = fe_cnt;
    send_frame(8'h1C, 1'b1, 11);
    check("t3_frame_err", fe_cnt, fe0 + 1);
    check("t3_valid", int'(valid), 0);
    check("t3_key_count", int'(key_count), 3);

    // overflow with nine repeats of '1'
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i < DEPTH) exp_q.push_back(8'h31);
      send(8'h16);
    end
    check("t4_overflow", int'(overflow), 1);
    check("t4_key_count", int'(key_count), 8);
    check("t4_valid", int'(valid), 1);
    check("t4_ascii", int'(ascii), 'h31);
    p0 = pop_cnt;
    drain();
    check("t4_pops", pop_cnt - p0, 8);
    check("t4_overflow_sticky", int'(overflow), 1);

    // start + 5 data bits then silence
    fe0 = fe_cnt;
    send_frame(8'h00, 1'b0, 6);
    tick(TMO + 20);
    check("t5_timeout_err", fe_cnt, fe0 + 1);
    exp_q.push_back(8'h30);
    send(8'h45);
    check("t5_ascii", int'(ascii), 'h30);
    check("t5_key_count", int'(key_count), 9);
    drain();

    // unmapped code dropped silently, space mapped
    fe0 = fe_cnt;
    exp_q.push_back(8'h20);
    send(8'h76); send(8'h29);
    check("t6_key_count", int'(key_count), 10);
    check("t6_no_err", fe_cnt, fe0);
    // extended make/break produce nothing
    exp_q.push_back(8'h7A);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h1A);
    check("t6_ext_key_count", int'(key_count), 11);
    check("t6_head", int'(ascii), 'h20);
    drain();

    // reset in the middle of a frame
    exp_q.push_back(8'h7A);
    send(8'h1A);
    send_frame(8'h1A, 1'b0, 4);
    do_reset();
    check("t7_ascii", int'(ascii), 0);
    check("t7_valid", int'(valid), 0);
    check("t7_overflow", int'(overflow), 0);
    check("t7_frame_err", int'(frame_err), 0);
    check("t7_key_count", int'(key_count), 0);
    exp_q.push_back(8'h7A);
    send(8'h1A);
    check("t7_clean_ascii", int'(ascii), 'h7A);
    check("t7_clean_key_count", int'(key_count), 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
